// File: rtl/async_fifo_mq_rd_sched.sv
// Round-robin read scheduler for the multi-queue async FIFO, read clock domain.
// Latency: one idle cycle per grant; q_valid/q_queue follow read by one clock.
// Backpressure: a burst stops in the same cycle its queue is empty or its consumer is not ready.
module async_fifo_mq_rd_sched #(
    parameter int nr_of_queues = 16,
    parameter int a_hi_size    = 4,
    parameter int burst_max    = 4,
    parameter int cnt_width    = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    enable,
    input  logic [0:nr_of_queues-1] fifo_empty,
    input  logic [0:nr_of_queues-1] dst_ready,
    output logic                    read,
    output logic [0:nr_of_queues-1] read_enable,
    output logic                    q_valid,
    output logic [a_hi_size-1:0]    q_queue,
    output logic                    busy
);

    typedef enum logic {IDLE, BURST} state_t;

    state_t                  state, state_nxt;
    logic [0:nr_of_queues-1] g, g_nxt;
    logic [a_hi_size-1:0]    last, last_nxt;
    logic [cnt_width-1:0]    count, count_nxt;
    logic [0:nr_of_queues-1] elig;
    logic                    g_elig;
    logic                    pick_vld;
    logic [a_hi_size-1:0]    pick_idx;
    logic [a_hi_size-1:0]    j;

    assign elig   = ~fifo_empty & dst_ready;
    assign g_elig = |(elig & g);
    assign busy   = (state == BURST);

    // Round-robin pick: first eligible queue after the last granted one, wrapping.
    always_comb begin
        pick_vld = 1'b0;
        pick_idx = '0;
        j        = '0;
        for (int k = 1; k <= nr_of_queues; k++) begin
            j = a_hi_size'((int'(last) + k) % nr_of_queues);
            if (!pick_vld && elig[j]) begin
                pick_vld = 1'b1;
                pick_idx = j;
            end
        end
    end

    // Next state and read strobes; read is only issued while the granted queue stays eligible.
    always_comb begin
        state_nxt   = state;
        g_nxt       = g;
        last_nxt    = last;
        count_nxt   = count;
        read        = 1'b0;
        read_enable = '0;
        if (state == IDLE) begin
            if (enable && pick_vld) begin
                state_nxt       = BURST;
                g_nxt           = '0;
                g_nxt[pick_idx] = 1'b1;
                last_nxt        = pick_idx;
                count_nxt       = '0;
            end
        end else begin
            read_enable = g;
            read        = g_elig;
            if (g_elig) begin
                count_nxt = count + cnt_width'(1);
            end
            // Leaving on a full burst or on loss of eligibility; the latter also covers
            // the case where the final count and an empty flag coincide.
            if (!g_elig || count == cnt_width'(burst_max - 1)) begin
                state_nxt = IDLE;
                g_nxt     = '0;
            end
        end
    end

    // Grant state; last starts at the top queue so queue 0 wins the first arbitration.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            g     <= '0;
            last  <= a_hi_size'(nr_of_queues - 1);
            count <= '0;
        end else begin
            state <= state_nxt;
            g     <= g_nxt;
            last  <= last_nxt;
            count <= count_nxt;
        end
    end

    // Return-data tag: the FIFO RAM read is registered, so q lines up one clock after read.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q_valid <= 1'b0;
            q_queue <= '0;
        end else begin
            q_valid <= read;
            q_queue <= last;
        end
    end

endmodule

// File: doc/async_fifo_mq_rd_sched.md
Name: async_fifo_mq_rd_sched

Overview:
- Read-side scheduler for the multi-queue async FIFO; runs entirely in the read clock domain.
- Monitors the per-queue empty flags and downstream per-queue ready. Grants one queue at a time with round-robin priority and drives the FIFO's read/read_enable.
- Tags the data word returned one cycle later with its queue index.
- Sits between the FIFO read port and the per-queue consumers, e.g. SDRAM bank or port logic.

Parameters:
- nr_of_queues, 16, number of queues; equals the FIFO's queue count.
- a_hi_size, 4, queue index width; 2**a_hi_size >= nr_of_queues.
- burst_max, 4, maximum consecutive reads from one queue per grant (1..255).
- cnt_width, 8, burst counter width.

Ports:
- clk  in  1  read-side clock; same clock as the FIFO read clock.
- rst  in  1  asynchronous, active-low reset.
- enable  in  1  scheduler enable; when low, no new grant is taken.
- fifo_empty  in  [0:nr_of_queues-1]  per-queue empty flags from the FIFO.
- dst_ready  in  [0:nr_of_queues-1]  consumer for that queue can accept a word.
- read  out  1  FIFO read strobe.
- read_enable  out  [0:nr_of_queues-1]  one-hot queue select to the FIFO; zero when idle.
- q_valid  out  1  FIFO q output holds a valid word this cycle.
- q_queue  out  a_hi_size  queue index of the word on q.
- busy  out  1  a grant is active.

Behaviour:
- Reset (rst low, async): all outputs 0, FSM in IDLE, burst count 0, last-granted pointer = nr_of_queues-1, so queue 0 has first priority.
- Eligibility: elig[i] = ~fifo_empty[i] & dst_ready[i].
- FSM states: IDLE, BURST.
- IDLE:
  - If enable and |elig: choose the first eligible queue scanning last+1, last+2, ... modulo nr_of_queues.
  - Register one-hot grant g, set last = index(g), count = 0, go to BURST.
  - No read is issued in IDLE, so arbitration costs one cycle.
- BURST:
  - read = elig[g]; read_enable = g whenever in BURST (read_enable is held even when read is 0). read is combinational from registered g and the inputs.
  - On each read, count increments.
  - Exit to IDLE at the clock edge when any of:
    - read and count == burst_max-1, i.e. the burst is complete;
    - fifo_empty[g] is 1;
    - dst_ready[g] is 0.
  - The exit happens in the same cycle that condition is seen; no read occurs in a cycle where elig[g] is 0.
  - enable low does not abort a burst in progress; it only blocks the next grant.
- Return data: the FIFO RAM has a registered read, so q is valid one clock after read.
  - q_valid is read delayed one cycle.
  - q_queue is index(g) delayed one cycle.
  - Both are registered. q_valid for the final read of a burst asserts the cycle after the FSM has already returned to IDLE.
- Fairness:
  - A queue granted last gets lowest priority in the next arbitration.
  - With all queues continuously eligible, each queue receives burst_max reads every nr_of_queues*(burst_max+1) cycles.
- Empty-flag timing:
  - fifo_empty rises via the FIFO's pointer compare after the read pointer advances.
  - The scheduler relies only on the current-cycle flag. A read in cycle t must not empty the queue unseen; the FIFO pointer update at t+1 sets empty before the next read decision.
  - A read is never issued when fifo_empty[g] = 1.
- Simultaneous events: if fifo_empty[g] rises and the count reaches burst_max-1 in the same cycle, there is no read and the FSM goes to IDLE; the count does not matter.
- Invariants:
  - read_enable is one-hot or zero at all times.
  - read implies read_enable == g.
  - busy = (state == BURST).
- Reset mid-burst: all outputs drop asynchronously. A pending q_valid is discarded. After reset, arbitration restarts at queue 0.

Test Plan:
- Single queue: reset; queue 5 holds 10 words, dst_ready all 1. Expect grant at cycle 1; reads of 4, 4, 2 words, each burst separated by one idle cycle; q_valid 10 times with q_queue = 5; then IDLE with busy = 0.
- Round robin: queues 0, 3 and 15 non-empty with 8 words each, burst_max = 4. Expect grant order 0, 3, 15, 0, 3, 15, 4 reads each; order wraps correctly after 15.
- Backpressure: during a burst on queue 2, drop dst_ready[2] after the 2nd read. Expect no read that cycle, FSM to IDLE, a different eligible queue granted next; queue 2 is served again in its turn once ready.
- Empty mid-burst: queue 7 holds 2 words, burst_max = 4. Expect exactly 2 reads, fifo_empty[7] seen, exit to IDLE, no read while empty, q_valid pulses 2.
- Enable and reset: enable = 0 with data pending gives no grant. Raise enable and assert rst low mid-burst: read, read_enable, q_valid and busy go 0 immediately. After release, the first grant goes to the lowest-index eligible queue.
- Invariant check on random traffic, 10k cycles: read_enable is always one-hot/zero, there is never a read with the granted queue empty, and per-queue read counts equal q_valid counts.
